rev_gpio_apb_arb: RTL and testbench
===================================

REV_GPIO_APB_ARB -- requirements
Module: rev_gpio_apb_arb

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_W, default 32: APB data width, multiple of 8.
- ADDR_W, default 4: APB address width.
- TIMEOUT, default 16: maximum ACCESS cycles without pready; minimum 2.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The ports SHALL be, clock and reset first:
- pclk  in  1  clock.
- prstn  in  1  asynchronous active-low reset.
- req  in  2  per-requester request level.
- req_we  in  2  per-requester write(1)/read(0).
- req_addr  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  requester i at [i*DATA_W +: DATA_W].
- req_strb  in  2*DATA_W/8  requester i byte strobes.
- gnt  out  2  one-hot pulse: request accepted, payload sampled.
- rsp_valid  out  2  one-hot pulse: transaction complete.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- psel, penable, pwrite  out  1 each  APB master controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB write strobes.
- pready, pslverr  in  1 each  APB slave responses.
- prdata  in  DATA_W  APB slave read data.

Function
REQ-004 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-005 In IDLE with any req bit high, gnt SHALL pulse combinationally for exactly one requester in that cycle, and that requester's we/addr/wdata/strb SHALL be latched at the clock edge.
REQ-006 After a grant, the FSM SHALL go IDLE->SETUP with psel=1, penable=0, then SETUP->ACCESS with psel=1, penable=1.
REQ-007 paddr, pwrite, pwdata and pstrb SHALL hold the latched values throughout SETUP and ACCESS.
REQ-008 For reads, pwdata SHALL be 0 and pstrb SHALL be 0.
REQ-009 In ACCESS with pready=1, the block SHALL capture prdata (reads) or 0 (writes) into rsp_rdata and pslverr into rsp_err, then return to IDLE.
REQ-010 rsp_valid for the owner SHALL pulse for one cycle in that next cycle, with rsp_rdata/rsp_err held until the next completion.
REQ-011 Minimum latency SHALL be 3 cycles: gnt at T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3.
REQ-012 A new gnt MAY occur in the same cycle as rsp_valid.
REQ-013 Arbitration SHALL be round-robin over a 1-bit pointer naming the preferred requester.
REQ-014 On each gnt, the pointer SHALL update to the non-granted requester.
REQ-015 With a single requester active, that requester SHALL always win, independent of the pointer.
REQ-016 With both req bits high in the same cycle, the pointer SHALL decide.
REQ-017 gnt SHALL never assert outside IDLE.
REQ-018 A req that stays high after gnt SHALL be treated as a new request.
REQ-019 A req deasserted before gnt SHALL be dropped without side effects.
REQ-020 A timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-021 When the counter reaches TIMEOUT-1 with pready=0, the block SHALL abort: go to IDLE, drop psel/penable, and report rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-022 A pready arriving in the same cycle as the timeout SHALL win, and the transfer completes normally.
REQ-023 Only the transaction owner SHALL receive rsp_valid.
REQ-024 rsp_valid and gnt SHALL each be one-hot or zero.
REQ-025 penable SHALL never be high without psel.

Reset
REQ-026 While prstn=0, the block SHALL be forced to the following, independent of pclk:
- FSM in IDLE, pointer=0 (requester 0 preferred), timeout counter=0.
- psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata and rsp_err all 0.
REQ-027 gnt SHALL be 0 during reset.
REQ-028 A reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid.

Verification
REQ-029 Single write: req[0]=1, we=1, addr=0x1, wdata=0x000000FF, strb=0xF, pready=1 -> gnt[0] at T; psel at T+1; penable at T+2 with paddr=0x1, pwdata=0x000000FF; rsp_valid[0]=1 and rsp_err=0 at T+3.
REQ-030 Single read: req[1] read addr=0x3 with prdata=0xA5A5A5A5 -> rsp_valid[1] at T+3 with rsp_rdata=0xA5A5A5A5, pstrb=0 throughout.
REQ-031 Contention: req=2'b11 from reset, both held -> grants gnt[0], gnt[1], gnt[0], gnt[1] at T, T+3, T+6, T+9.
REQ-032 Wait states: pready low for 3 ACCESS cycles -> psel/penable held and address stable, rsp_valid 3 cycles late, rsp_err=0.
REQ-033 Timeout and slave error:
- pready held 0 with TIMEOUT=16 -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
- pready=1 with pslverr=1 -> rsp_err=1.
REQ-034 Mid-transfer reset: prstn low during ACCESS -> psel=penable=0 immediately, no rsp_valid. After release with req=2'b11 -> gnt[0] first.

Source files
------------

// File: rtl/rev_gpio_apb_arb.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Grants in IDLE, runs one SETUP/ACCESS transfer, returns the response to the owner.
module rev_gpio_apb_arb #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    pclk,
    input  logic                    prstn,
    input  logic [1:0]              req,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]     req_wdata,
    input  logic [2*DATA_W/8-1:0]   req_strb,
    output logic [1:0]              gnt,
    output logic [1:0]              rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_W-1:0]       paddr,
    output logic [DATA_W-1:0]       pwdata,
    output logic [DATA_W/8-1:0]     pstrb,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [DATA_W-1:0]       prdata
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                ptr_q;
    logic                owner_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                psel_q;
    logic                penable_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                gnt_any_c;
    logic                gnt_idx_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;
    logic [STRB_W-1:0]   sel_strb_c;

    // Round-robin pick: a lone requester wins outright, the pointer breaks ties.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_idx_c = 1'b0;
        gnt       = 2'b00;
        if (prstn && (state_q == ST_IDLE) && (req != 2'b00)) begin
            gnt_any_c = 1'b1;
            gnt_idx_c = (req == 2'b11) ? ptr_q : req[1];
            gnt       = gnt_idx_c ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        sel_we_c    = gnt_idx_c ? req_we[1] : req_we[0];
        sel_addr_c  = gnt_idx_c ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata_c = gnt_idx_c ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        sel_strb_c  = gnt_idx_c ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            tmo_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any_c) begin
                        owner_q <= gnt_idx_c;
                        ptr_q   <= ~gnt_idx_c;
                        we_q    <= sel_we_c;
                        addr_q  <= sel_addr_c;
                        // Reads drive zero data and strobes onto the bus.
                        wdata_q <= sel_we_c ? sel_wdata_c : '0;
                        strb_q  <= sel_we_c ? sel_strb_c : '0;
                        psel_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    tmo_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready takes priority over an expiring timeout.
                    if (pready) begin
                        rsp_rdata_q <= we_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = we_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign pstrb     = strb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rev_gpio_apb_arb.sv
// Directed bench for rev_gpio_apb_arb: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_rev_gpio_apb_arb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = DW / 8;

    logic              pclk = 1'b0;
    logic              prstn;
    logic [1:0]        req;
    logic [1:0]        req_we;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [2*SW-1:0]   req_strb;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic              pready, pslverr;
    logic [DW-1:0]     prdata;

    int checks   = 0;
    int failures = 0;

    rev_gpio_apb_arb #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(16)) dut (
        .pclk(pclk), .prstn(prstn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_we[i]          = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
    endtask

    task automatic idle_cycle();
        @(negedge pclk);
        req = 2'b00;
        #1;
    endtask

    task automatic test_reset();
        prstn = 1'b0; req = 2'b11; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        req_we = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        @(negedge pclk); #1;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
        checks++; if ({psel, penable, pwrite} !== 3'b000) begin failures++; $display("FAIL rst_ctrl got=%b exp=000", {psel, penable, pwrite}); end
        checks++; if ({paddr, pwdata, pstrb} !== '0) begin failures++; $display("FAIL rst_bus got=%h exp=0", {paddr, pwdata, pstrb}); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== '0) begin failures++; $display("FAIL rst_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_rdata}); end
        @(negedge pclk); req = 2'b00; prstn = 1'b1; #1;
        idle_cycle();
    endtask

    task automatic test_single_write();
        @(negedge pclk);
        set_req(0, 1'b1, 4'h1, 32'h0000_00FF, 4'hF);
        req = 2'b01; pready = 1'b1; pslverr = 1'b0; #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt got=%b exp=01", gnt); end
        @(negedge pclk); req = 2'b00; #1;
        checks++; if ({psel, penable, gnt} !== 4'b1000) begin failures++; $display("FAIL wr_setup got=%b exp=1000", {psel, penable, gnt}); end
        @(negedge pclk); #1;
        checks++; if ({psel, penable, pwrite} !== 3'b111) begin failures++; $display("FAIL wr_access got=%b exp=111", {psel, penable, pwrite}); end
        checks++; if ({paddr, pwdata, pstrb} !== {4'h1, 32'h0000_00FF, 4'hF}) begin failures++; $display("FAIL wr_bus got=%h exp=%h", {paddr, pwdata, pstrb}, {4'h1, 32'h0000_00FF, 4'hF}); end
        @(negedge pclk); #1;
        checks++; if ({rsp_valid, rsp_err, psel} !== 4'b0100) begin failures++; $display("FAIL wr_rsp got=%b exp=0100", {rsp_valid, rsp_err, psel}); end
        idle_cycle();
    endtask

    task automatic test_single_read();
        @(negedge pclk);
        set_req(1, 1'b0, 4'h3, 32'h1234_5678, 4'hF);
        req = 2'b10; pready = 1'b1; prdata = 32'hA5A5_A5A5; #1;
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rd_gnt got=%b exp=10", gnt); end
        @(negedge pclk); req = 2'b00; #1;
        checks++; if ({psel, pwrite, pwdata, pstrb} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin failures++; $display("FAIL rd_setup got=%h", {psel, pwrite, pwdata, pstrb}); end
        @(negedge pclk); #1;
        checks++; if ({penable, paddr, pstrb} !== {1'b1, 4'h3, 4'h0}) begin failures++; $display("FAIL rd_access got=%h exp=%h", {penable, paddr, pstrb}, {1'b1, 4'h3, 4'h0}); end
        @(negedge pclk); #1;
        checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL rd_valid got=%b exp=10", rsp_valid); end
        checks++; if ({rsp_err, rsp_rdata} !== {1'b0, 32'hA5A5_A5A5}) begin failures++; $display("FAIL rd_data got=%h exp=0a5a5a5a5", {rsp_err, rsp_rdata}); end
        idle_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] eg, ev;
        @(negedge pclk); prstn = 1'b0; req = 2'b00; #1;
        @(negedge pclk); prstn = 1'b1; #1;
        set_req(0, 1'b1, 4'h4, 32'h1111_1111, 4'h3);
        set_req(1, 1'b1, 4'h8, 32'h2222_2222, 4'hC);
        pready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge pclk); req = 2'b11; #1;
            eg = (c == 0 || c == 6) ? 2'b01 : (c == 3 || c == 9) ? 2'b10 : 2'b00;
            ev = (c == 3 || c == 9) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
            checks++; if (rsp_valid !== ev) begin failures++; $display("FAIL rr_valid c=%0d got=%b exp=%b", c, rsp_valid, ev); end
        end
        @(negedge pclk); req = 2'b00; #1;
        checks++; if ({gnt, rsp_valid} !== 4'b0010) begin failures++; $display("FAIL rr_tail got=%b exp=0010", {gnt, rsp_valid}); end
        idle_cycle();
    endtask

    task automatic test_wait_states();
        @(negedge pclk);
        set_req(0, 1'b0, 4'h6, 32'h0, 4'h0);
        req = 2'b01; pready = 1'b0; prdata = 32'hDEAD_BEEF; #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL ws_gnt got=%b exp=01", gnt); end
        @(negedge pclk); req = 2'b00; #1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge pclk);
            if (k == 5) pready = 1'b1;
            #1;
            checks++; if ({psel, penable, paddr, rsp_valid} !== {2'b11, 4'h6, 2'b00}) begin failures++; $display("FAIL ws_hold k=%0d got=%h", k, {psel, penable, paddr, rsp_valid}); end
        end
        @(negedge pclk); #1;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'hDEAD_BEEF}) begin failures++; $display("FAIL ws_rsp got=%h", {rsp_valid, rsp_err, rsp_rdata}); end
        idle_cycle();
    endtask

    task automatic test_timeout();
        int  n;
        logic done;
        n = 0; done = 1'b0;
        @(negedge pclk);
        set_req(0, 1'b0, 4'h9, 32'h0, 4'h0);
        req = 2'b01; pready = 1'b0; prdata = 32'h1111_1111; #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL to_gnt got=%b exp=01", gnt); end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk); req = 2'b00; #1;
            if (penable) n++;
            else if (!psel && n > 0) done = 1'b1;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL to_bound got=%b exp=1", done); end
        checks++; if (n != 16) begin failures++; $display("FAIL to_cycles got=%0d exp=16", n); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin failures++; $display("FAIL to_rsp got=%h", {rsp_valid, rsp_err, rsp_rdata}); end
        idle_cycle();
    endtask

    task automatic test_timeout_race();
        @(negedge pclk);
        set_req(0, 1'b0, 4'hA, 32'h0, 4'h0);
        req = 2'b01; pready = 1'b0; prdata = 32'h0BAD_F00D; #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL race_gnt got=%b exp=01", gnt); end
        for (int k = 1; k <= 17; k++) begin
            @(negedge pclk); req = 2'b00;
            if (k == 17) pready = 1'b1;
            #1;
        end
        checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL race_hold got=%b exp=11", {psel, penable}); end
        @(negedge pclk); pready = 1'b0; #1;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0BAD_F00D}) begin failures++; $display("FAIL race_rsp got=%h", {rsp_valid, rsp_err, rsp_rdata}); end
        idle_cycle();
    endtask

    task automatic test_slverr();
        @(negedge pclk);
        set_req(0, 1'b1, 4'h2, 32'hCAFE_0001, 4'h1);
        req = 2'b01; pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF; #1;
        @(negedge pclk); req = 2'b00; #1;
        @(negedge pclk); #1;
        @(negedge pclk); pslverr = 1'b0; #1;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin failures++; $display("FAIL serr_rsp got=%h", {rsp_valid, rsp_err, rsp_rdata}); end
        idle_cycle();
    endtask

    task automatic test_mid_reset();
        @(negedge pclk);
        set_req(0, 1'b1, 4'h5, 32'h5555_5555, 4'hF);
        set_req(1, 1'b1, 4'h7, 32'h7777_7777, 4'hF);
        req = 2'b01; pready = 1'b0; #1;
        @(negedge pclk); req = 2'b00; #1;
        @(negedge pclk); #1;
        checks++; if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL mr_pre got=%b exp=11", {psel, penable}); end
        #1 prstn = 1'b0; #1;
        checks++; if ({psel, penable} !== 2'b00) begin failures++; $display("FAIL mr_async got=%b exp=00", {psel, penable}); end
        @(negedge pclk); req = 2'b11; pready = 1'b1; #1;
        checks++; if ({gnt, rsp_valid} !== 4'b0000) begin failures++; $display("FAIL mr_hold got=%b exp=0000", {gnt, rsp_valid}); end
        @(negedge pclk); prstn = 1'b1; #1;
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mr_gnt got=%b exp=01", gnt); end
        for (int k = 1; k <= 2; k++) begin
            @(negedge pclk); req = 2'b00; #1;
            checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mr_norsp k=%0d got=%b exp=00", k, rsp_valid); end
        end
        @(negedge pclk); #1;
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL mr_rsp got=%b exp=01", rsp_valid); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_timeout_race();
        test_slverr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
